sm83_bus_responder: RTL and testbench
=====================================

// Module: sm83_bus_responder
// PURPOSE
//  Memory-side responder at the far end of the SM83 external databus: answers core RD/WR cycles on
//  A[15:0]/DataBus. Owns a byte-wide RAM window, inserts programmable wait states and drives read data onto DataBus.
//  It captures write data that the core drives onto DataBus. Used as bench RAM and as the template for peripheral
//  responders in the SoC model.
// PARAMETERS
//  BASE         16'hC000  first address of the window (aligned to 2**ADDR_BITS)
//  ADDR_BITS    13        window size = 2**ADDR_BITS bytes (valid 1..15)
//  WAIT_STATES  0         extra CLK cycles between access acceptance and data phase (0..15)
// PORTS
//  CLK       in     1   clock; all state changes on posedge
//  nRESET    in     1   asynchronous, active-low reset
//  A         in     16  address from core
//  RD        in     1   core read strobe (active high)
//  WR        in     1   core write strobe (active high)
//  DataBus   inout  8   external databus; driven only as below, else 8'bz (bus precharge/pull-up resolves 1)
//  Ready     out    1   1 = no access pending in wait states (core may proceed)
//  Conflict  out    1   1-cycle pulse: RD&WR both high while selected
// BEHAVIOUR
//  - sel = (A[15:ADDR_BITS] == BASE[15:ADDR_BITS]). Unselected cycles: no state change, DataBus z, Ready=1.
//  - Reset (nRESET=0, async): state=IDLE, wcnt=0, rdata=8'h00, drive disabled immediately, Ready=1, Conflict=0.
//    RAM contents are not cleared. An access in progress at reset is abandoned; a pending write is not performed.
//  - States: IDLE, WAIT, RDRV (read drive), WCAP (write capture).
//  - IDLE, posedge, sel:
//      RD&~WR -> WAIT_STATES==0 ? RDRV : WAIT (wcnt=WAIT_STATES-1)
//      WR&~RD -> WAIT_STATES==0 ? WCAP : WAIT (wcnt=WAIT_STATES-1)
//      RD&WR  -> stay IDLE; Conflict=1 for that cycle; RAM untouched.
//    The kind (rd/wr) and A[ADDR_BITS-1:0] are latched at acceptance.
//  - WAIT: Ready=0. Decrement wcnt each posedge; at wcnt==0 go to RDRV or WCAP per latched kind.
//    If both strobes drop while in WAIT, abort to IDLE (no RAM access).
//  - RDRV: on entry, rdata <= RAM[latched addr]. DataBus = rdata while CLK==1; z while CLK==0 (core precharge phase).
//    Stay while RD=1 and the address is unchanged. If A changes with RD=1, reload rdata next posedge (no new wait states).
//    RD=0 -> IDLE, and drive is released in the same cycle the state leaves RDRV.
//  - WCAP: on the posedge in WCAP with WR=1, RAM[latched addr] <= DataBus; then stay until WR=0, then go to IDLE.
//    Only one write per accepted access. If WR=0 on the first WCAP edge, the write is dropped -> IDLE.
//  - Ready = ~(state==WAIT). Read latency: data valid on DataBus WAIT_STATES+1 posedges after RD is sampled.
//  - Responder never drives DataBus while WR=1 or state!=RDRV (no contention with core write drive).
//  - X/Z on DataBus in WCAP are written as-is (sim only); the bench must flag them.
// TESTING
//  1 WAIT_STATES=0: WR A=C000 D=5A for 2 cycles, then RD A=C000 -> DataBus=5A while CLK=1 from the 1st edge after RD; Ready stays 1.
//  2 WAIT_STATES=3: RD A=DFFF (preloaded A5) -> Ready=0 for exactly 3 cycles, DataBus z during them, then A5 driven.
//  3 RD A=E000 (outside window) -> DataBus stays z, state IDLE, Ready=1; RD A=BFFF likewise.
//  4 RD=1 WR=1 at A=C010 -> Conflict pulses 1 cycle, RAM[0x010] unchanged (read back matches old value).
//  5 WAIT_STATES=2, WR accepted, nRESET low in WAIT -> drive off, Ready=1 at once; after reset the RAM byte is unchanged.
//  6 Burst reads with RD held: A steps C000..C003 each cycle -> DataBus follows RAM with 1-cycle reload, no wait states.

Source files
------------

// File: rtl/sm83_bus_responder_if.sv
// Core-side strobe and status signals of the SM83 external bus, as seen by a memory-side
// responder. DataBus is carried as a plain inout next to this bundle.
interface sm83_bus_responder_if;
  logic [15:0] A;
  logic        RD;
  logic        WR;
  logic        Ready;
  logic        Conflict;

  modport master (
    output A,
    output RD,
    output WR,
    input  Ready,
    input  Conflict
  );

  modport slave (
    input  A,
    input  RD,
    input  WR,
    output Ready,
    output Conflict
  );
endinterface

// File: rtl/sm83_bus_responder.sv
// Memory-side responder for SM83 RD/WR cycles: byte RAM window, programmable wait states,
// read data driven onto DataBus during the high clock phase only.
module sm83_bus_responder #(
  parameter logic [15:0] BASE        = 16'hC000,
  parameter int unsigned ADDR_BITS   = 13,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  sm83_bus_responder_if.slave   bus,
  inout  wire  [7:0]            DataBus
);

  localparam int unsigned Depth = 1 << ADDR_BITS;
  localparam logic [3:0]  WcntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRdrv, StWcap} state_e;

  state_e               state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic                 kind_wr_q, kind_wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 wdone_q, wdone_d;
  logic                 conflict_q, conflict_d;
  logic                 mem_we;
  logic [7:0]           mem_q [Depth];

  logic                 sel;
  logic [ADDR_BITS-1:0] a_lo;
  logic                 drive;

  assign sel  = (bus.A[15:ADDR_BITS] == BASE[15:ADDR_BITS]);
  assign a_lo = bus.A[ADDR_BITS-1:0];

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    kind_wr_d  = kind_wr_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    wdone_d    = wdone_q;
    conflict_d = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sel) begin
          if (bus.RD && bus.WR) begin
            conflict_d = 1'b1;
          end else if (bus.RD || bus.WR) begin
            kind_wr_d = bus.WR;
            addr_d    = a_lo;
            wdone_d   = 1'b0;
            if (WAIT_STATES == 0) begin
              state_d = bus.WR ? StWcap : StRdrv;
              if (bus.RD) rdata_d = mem_q[a_lo];
            end else begin
              state_d = StWait;
              wcnt_d  = WcntInit;
            end
          end
        end
      end

      StWait: begin
        if (!bus.RD && !bus.WR) begin
          state_d = StIdle;
        end else if (wcnt_q == 4'd0) begin
          state_d = kind_wr_q ? StWcap : StRdrv;
          if (!kind_wr_q) rdata_d = mem_q[addr_q];
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end

      StRdrv: begin
        if (!bus.RD || !sel) begin
          state_d = StIdle;
        end else if (a_lo != addr_q) begin
          // Address moved under a held strobe: reload without new wait states.
          addr_d  = a_lo;
          rdata_d = mem_q[a_lo];
        end
      end

      StWcap: begin
        if (!wdone_q) begin
          if (bus.WR) begin
            mem_we  = 1'b1;
            wdone_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (!bus.WR) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= StIdle;
      wcnt_q     <= 4'd0;
      kind_wr_q  <= 1'b0;
      addr_q     <= '0;
      rdata_q    <= 8'h00;
      wdone_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      kind_wr_q  <= kind_wr_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      wdone_q    <= wdone_d;
      conflict_q <= conflict_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[addr_q] <= DataBus;
  end

  // Low clock phase is the core's precharge phase, so the bus is released then.
  assign drive        = (state_q == StRdrv) && CLK && !bus.WR;
  assign DataBus      = drive ? rdata_q : 8'bz;
  assign bus.Ready    = (state_q != StWait);
  assign bus.Conflict = conflict_q;

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Randomized bench: three responders (0, 3 and 2 wait states) checked against a
// transaction-level RAM model with expected latencies derived from the wait-state count.
module tb_sm83_bus_responder;

  localparam int WS [3] = '{0, 3, 2};

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic        rd;
  logic        wr;
  logic        drv;
  logic [7:0]  wdata;
  int          cur;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ref_mem [3][8192];
  logic [15:0] pool [16];

  sm83_bus_responder_if u_if0 ();
  sm83_bus_responder_if u_if1 ();
  sm83_bus_responder_if u_if2 ();

  wire [7:0] db0;
  wire [7:0] db1;
  wire [7:0] db2;
  pullup (db0);
  pullup (db1);
  pullup (db2);

  assign db0 = (drv && cur == 0) ? wdata : 8'bz;
  assign db1 = (drv && cur == 1) ? wdata : 8'bz;
  assign db2 = (drv && cur == 2) ? wdata : 8'bz;

  assign u_if0.A  = a;
  assign u_if1.A  = a;
  assign u_if2.A  = a;
  assign u_if0.RD = rd && (cur == 0);
  assign u_if1.RD = rd && (cur == 1);
  assign u_if2.RD = rd && (cur == 2);
  assign u_if0.WR = wr && (cur == 0);
  assign u_if1.WR = wr && (cur == 1);
  assign u_if2.WR = wr && (cur == 2);

  sm83_bus_responder #(.BASE(16'hC000), .ADDR_BITS(13), .WAIT_STATES(0)) u_dut0 (
    .CLK(clk), .nRESET(rst_n), .bus(u_if0.slave), .DataBus(db0)
  );
  sm83_bus_responder #(.BASE(16'hC000), .ADDR_BITS(13), .WAIT_STATES(3)) u_dut1 (
    .CLK(clk), .nRESET(rst_n), .bus(u_if1.slave), .DataBus(db1)
  );
  sm83_bus_responder #(.BASE(16'hC000), .ADDR_BITS(13), .WAIT_STATES(2)) u_dut2 (
    .CLK(clk), .nRESET(rst_n), .bus(u_if2.slave), .DataBus(db2)
  );

  logic [7:0] db_cur;
  logic       ready_cur;
  logic       confl_cur;

  always_comb begin
    db_cur    = db0;
    ready_cur = u_if0.Ready;
    confl_cur = u_if0.Conflict;
    if (cur == 1) begin
      db_cur    = db1;
      ready_cur = u_if1.Ready;
      confl_cur = u_if1.Conflict;
    end else if (cur == 2) begin
      db_cur    = db2;
      ready_cur = u_if2.Ready;
      confl_cur = u_if2.Conflict;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (dut %0d): got %h expected %h", tag, cur, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [15:0] addr);
    return addr[15:13] == 3'b110;
  endfunction

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    int ws;
    bit hit;
    ws  = WS[cur];
    hit = in_win(addr);
    @(negedge clk);
    a = addr; wr = 1'b1; wdata = data; drv = 1'b1;
    for (int i = 1; i <= ws + 2; i++) begin
      @(posedge clk); #2;
      check("wr_ready", {15'd0, ready_cur}, (hit && i <= ws) ? 16'd0 : 16'd1);
      if (i == ws + 2) begin
        check("wr_bus_known", {15'd0, $isunknown(db_cur)}, 16'd0);
        check("wr_bus", {8'd0, db_cur}, {8'd0, data});
      end
    end
    @(negedge clk);
    wr = 1'b0; drv = 1'b0;
    @(posedge clk); #2;
    if (hit) ref_mem[cur][addr[12:0]] = data;
  endtask

  task automatic do_read(input logic [15:0] addr);
    int ws;
    bit hit;
    logic [7:0] exp;
    ws  = WS[cur];
    hit = in_win(addr);
    exp = hit ? ref_mem[cur][addr[12:0]] : 8'hFF;
    @(negedge clk);
    a = addr; rd = 1'b1;
    if (hit) begin
      for (int i = 1; i <= ws; i++) begin
        @(posedge clk); #2;
        check("rd_wait_ready", {15'd0, ready_cur}, 16'd0);
        check("rd_wait_bus", {8'd0, db_cur}, 16'h00FF);
      end
    end
    @(posedge clk); #2;
    check("rd_ready", {15'd0, ready_cur}, 16'd1);
    check("rd_data", {8'd0, db_cur}, {8'd0, exp});
    @(negedge clk); #1;
    check("rd_precharge", {8'd0, db_cur}, 16'h00FF);
    rd = 1'b0;
    @(posedge clk); #2;
    check("rd_release", {8'd0, db_cur}, 16'h00FF);
    check("rd_idle_ready", {15'd0, ready_cur}, 16'd1);
  endtask

  initial begin
    logic [7:0] old;
    rst_n = 1'b0; a = 16'h0000; rd = 1'b0; wr = 1'b0; drv = 1'b0; wdata = 8'h00; cur = 0;

    // Reset state of every instance.
    #2;
    for (int k = 0; k < 3; k++) begin
      cur = k;
      #1;
      check("rst_ready", {15'd0, ready_cur}, 16'd1);
      check("rst_conflict", {15'd0, confl_cur}, 16'd0);
      check("rst_bus", {8'd0, db_cur}, 16'h00FF);
    end
    cur = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Write then read back at C000 with no wait states.
    cur = 0;
    do_write(16'hC000, 8'h5A);
    do_read(16'hC000);

    // Three wait states at the top byte of the window.
    cur = 1;
    do_write(16'hDFFF, 8'hA5);
    do_read(16'hDFFF);

    // Just outside the window on both sides.
    for (int k = 0; k < 3; k++) begin
      cur = k;
      do_read(16'hE000);
      do_read(16'hBFFF);
    end

    // RD and WR together: one-cycle Conflict, RAM untouched.
    cur = 0;
    do_write(16'hC010, 8'h3C);
    @(negedge clk);
    a = 16'hC010; rd = 1'b1; wr = 1'b1;
    @(posedge clk); #2;
    check("conflict_pulse", {15'd0, confl_cur}, 16'd1);
    check("conflict_ready", {15'd0, ready_cur}, 16'd1);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #2;
    check("conflict_clear", {15'd0, confl_cur}, 16'd0);
    do_read(16'hC010);

    // Reset in the middle of a waited write: abandoned, byte keeps its old value.
    cur = 2;
    do_write(16'hC123, 8'h66);
    old = ref_mem[2][13'h0123];
    @(negedge clk);
    a = 16'hC123; wr = 1'b1; wdata = ~old; drv = 1'b1;
    @(posedge clk); #2;
    check("rstw_wait_ready", {15'd0, ready_cur}, 16'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rstw_ready", {15'd0, ready_cur}, 16'd1);
    check("rstw_conflict", {15'd0, confl_cur}, 16'd0);
    wr = 1'b0; drv = 1'b0;
    #1;
    check("rstw_bus", {8'd0, db_cur}, 16'h00FF);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(16'hC123);

    // Burst with RD held: one-cycle reload per address step.
    cur = 0;
    for (int i = 0; i < 4; i++) do_write(16'hC000 + 16'(i), 8'($urandom_range(0, 254)));
    @(negedge clk);
    a = 16'hC000; rd = 1'b1;
    @(posedge clk); #2;
    check("burst_0", {8'd0, db_cur}, {8'd0, ref_mem[0][0]});
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      a = 16'hC000 + 16'(i);
      @(posedge clk); #2;
      check("burst_n", {8'd0, db_cur}, {8'd0, ref_mem[0][i]});
      check("burst_ready", {15'd0, ready_cur}, 16'd1);
    end
    @(negedge clk);
    rd = 1'b0;
    @(posedge clk); #2;
    check("burst_release", {8'd0, db_cur}, 16'h00FF);

    // Randomized traffic on each instance over a shared address pool.
    for (int p = 0; p < 16; p++) pool[p] = 16'hC000 | 16'($urandom_range(0, 16'h1FFF));
    for (int k = 0; k < 3; k++) begin
      cur = k;
      for (int p = 0; p < 16; p++) do_write(pool[p], 8'($urandom));
      for (int n = 0; n < 30; n++) begin
        int op;
        int p;
        op = $urandom_range(0, 9);
        p  = $urandom_range(0, 15);
        if (op < 4) do_write(pool[p], 8'($urandom));
        else if (op < 9) do_read(pool[p]);
        else do_read(($urandom_range(0, 1) != 0) ? 16'hE000 | 16'($urandom_range(0, 16'h1FFF))
                                               : 16'($urandom_range(0, 16'hBFFF)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
